// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if
// Handshake and control bundle between the FIR MAC sequencer and its
// surroundings (sample source, delay-line RAM, coefficient ROM, MAC unit,
// result consumer).
//   in_valid / in_ready   : sample offer / sample accepted this cycle
//   clear                 : request zeroing of the delay line
//   dwe / dzero / daddr   : delay-line write enable, zero-data select, address
//   caddr                 : coefficient address
//   mac_op                : MAC command (NOP=00, LOAD=01, ACC=10, CLR=11)
//   out_valid / out_ready : result complete / consumer takes result
//   busy                  : sequencer is not idle
// The sequencer connects through the master modport; the environment connects
// through the slave modport.
interface fir_mac_sequencer_if #(
    parameter int FADDRBITS = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 clear;
    logic                 dwe;
    logic                 dzero;
    logic [FADDRBITS-1:0] daddr;
    logic [FADDRBITS-1:0] caddr;
    logic [1:0]           mac_op;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;

    modport master (
        input  in_valid, clear, out_ready,
        output in_ready, dwe, dzero, daddr, caddr, mac_op, out_valid, busy
    );

    modport slave (
        output in_valid, clear, out_ready,
        input  in_ready, dwe, dzero, daddr, caddr, mac_op, out_valid, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Control sequencer for a single-MAC FIR filter. It zero-fills the sample
// delay line, accepts one sample at a time, then walks the NTAPS coefficient /
// delay-line address pairs (newest sample first) and issues the matching MAC
// commands one cycle later to cover the synchronous read latency of the
// memories. The finished result is held until the consumer takes it.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fir_mac_sequencer_if master modport (handshakes, memory addresses,
//          MAC command, busy)
module fir_mac_sequencer #(
    parameter int NTAPS     = 7,
    parameter int FADDRBITS = $clog2(NTAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    fir_mac_sequencer_if.master     bus
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [FADDRBITS-1:0] LAST = FADDRBITS'(NTAPS - 1);
    localparam logic [FADDRBITS-1:0] ONE  = FADDRBITS'(1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    logic [FADDRBITS-1:0] k;
    logic [FADDRBITS-1:0] wp;
    logic [FADDRBITS-1:0] base;
    logic [1:0]           op_p1;

    // Circular delay-line arithmetic. When k exceeds b the result is
    // b + NTAPS - k, written as b + (NTAPS-1-k) + 1 so that no intermediate
    // value leaves the FADDRBITS range.
    function automatic logic [FADDRBITS-1:0] wrap_sub(
        input logic [FADDRBITS-1:0] b,
        input logic [FADDRBITS-1:0] kk
    );
        if (kk > b)
            return b + (LAST - kk) + ONE;
        return b - kk;
    endfunction

    function automatic logic [FADDRBITS-1:0] wrap_inc(
        input logic [FADDRBITS-1:0] x
    );
        return (x == LAST) ? '0 : x + ONE;
    endfunction

    // Stage p0 -> p1: state, counters and the delayed MAC command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            k     <= '0;
            wp    <= '0;
            base  <= '0;
            op_p1 <= OP_NOP;
        end else begin
            unique case (state)
                S_INIT: begin
                    op_p1 <= OP_NOP;
                    if (k == LAST) begin
                        k     <= '0;
                        wp    <= '0;
                        state <= S_IDLE;
                    end else begin
                        k <= k + ONE;
                    end
                end
                S_IDLE: begin
                    op_p1 <= OP_NOP;
                    if (bus.clear) begin
                        k     <= '0;
                        state <= S_INIT;
                    end else if (bus.in_valid) begin
                        base  <= wp;
                        wp    <= wrap_inc(wp);
                        k     <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Command follows the address by one cycle: the first tap
                    // loads the accumulator, the rest accumulate.
                    op_p1 <= (k == '0) ? OP_LOAD : OP_ACC;
                    if (k == LAST) begin
                        k     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        k <= k + ONE;
                    end
                end
                S_DRAIN: begin
                    op_p1 <= OP_NOP;
                    state <= S_DONE;
                end
                S_DONE: begin
                    op_p1 <= OP_NOP;
                    if (bus.out_ready)
                        state <= S_IDLE;
                end
                default: begin
                    op_p1 <= OP_NOP;
                    state <= S_INIT;
                end
            endcase
        end
    end

    // Output decode: addresses and write strobes follow the current state
    // (and the handshake inputs while idle); mac_op comes from op_p1 except
    // during the zero fill, where CLR is issued directly.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.dwe       = 1'b0;
        bus.dzero     = 1'b0;
        bus.daddr     = '0;
        bus.caddr     = '0;
        bus.mac_op    = OP_NOP;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        if (!rst) begin
            unique case (state)
                S_INIT: begin
                    bus.dwe    = 1'b1;
                    bus.dzero  = 1'b1;
                    bus.daddr  = k;
                    bus.mac_op = OP_CLR;
                end
                S_IDLE: begin
                    bus.busy     = 1'b0;
                    bus.in_ready = !bus.clear;
                    bus.dwe      = bus.in_valid && !bus.clear;
                    bus.daddr    = wp;
                    bus.mac_op   = op_p1;
                end
                S_MAC: begin
                    bus.caddr  = k;
                    bus.daddr  = wrap_sub(base, k);
                    bus.mac_op = op_p1;
                end
                S_DRAIN: begin
                    bus.mac_op = op_p1;
                end
                S_DONE: begin
                    bus.out_valid = 1'b1;
                    bus.mac_op    = op_p1;
                end
                default: begin
                    bus.mac_op = OP_NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer
// Directed bench for fir_mac_sequencer (NTAPS=7). A schedule-based model
// predicts every output on every cycle; literal expectations pin the key
// timing points of each scenario.
module tb_fir_mac_sequencer;
    localparam int N  = 7;
    localparam int AW = $clog2(N);
    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] ACC  = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_mac_sequencer_if #(.FADDRBITS(AW)) bus();
    fir_mac_sequencer #(.NTAPS(N), .FADDRBITS(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    endtask

    // Per-cycle log of DUT outputs, indexed by cycle number.
    logic [1:0] op_log [0:4095];
    logic       ov_log [0:4095];
    logic       ir_log [0:4095];
    logic       dwe_log[0:4095];
    int         da_log [0:4095];

    // Model: a queue of scheduled per-cycle expectations. An empty queue means
    // the block is either holding a result or idle.
    typedef struct {
        logic [6:0] ctrl;   // {in_ready, dwe, dzero, mac_op, out_valid, busy}
        int         da;
        int         ca;
        bit         chk_da;
        bit         chk_ca;
        bit         last;
    } rec_t;

    rec_t sched[$];
    bit   m_hold = 0;
    int   m_wp   = 0;

    function automatic rec_t mk(input logic [6:0] ctrl, input int da, input int ca,
                                input bit cda, input bit cca, input bit last);
        rec_t r;
        r.ctrl = ctrl; r.da = da; r.ca = ca;
        r.chk_da = cda; r.chk_ca = cca; r.last = last;
        return r;
    endfunction

    task automatic push_init();
        sched.delete();
        for (int i = 0; i < N; i++)
            sched.push_back(mk({1'b0, 1'b1, 1'b1, CLR, 1'b0, 1'b1}, i, 0, 1, 0, 0));
        m_wp   = 0;
        m_hold = 0;
    endtask

    task automatic push_compute(input int b);
        logic [1:0] op;
        for (int j = 0; j < N; j++) begin
            op = (j == 0) ? NOP : ((j == 1) ? LOAD : ACC);
            sched.push_back(mk({3'b000, op, 1'b0, 1'b1}, (b - j + N) % N, j, 1, 1, 0));
        end
        sched.push_back(mk({3'b000, ACC, 1'b0, 1'b1}, 0, 0, 0, 0, 1));
    endtask

    always @(negedge clk) begin
        rec_t e;
        rec_t r;
        logic [6:0] got;
        got = {bus.in_ready, bus.dwe, bus.dzero, bus.mac_op, bus.out_valid, bus.busy};
        if (rst)
            e = mk({3'b000, NOP, 1'b0, 1'b1}, 0, 0, 1, 1, 0);
        else if (sched.size() > 0)
            e = sched[0];
        else if (m_hold)
            e = mk({3'b000, NOP, 1'b1, 1'b1}, 0, 0, 0, 0, 0);
        else
            e = mk({!bus.clear, bus.in_valid && !bus.clear, 1'b0, NOP, 1'b0, 1'b0},
                   m_wp, 0, 1, 0, 0);
        check("ctrl", int'(got), int'(e.ctrl));
        if (e.chk_da) check("daddr", int'(bus.daddr), e.da);
        if (e.chk_ca) check("caddr", int'(bus.caddr), e.ca);
        if (cyc < 4096) begin
            op_log[cyc]  = bus.mac_op;
            ov_log[cyc]  = bus.out_valid;
            ir_log[cyc]  = bus.in_ready;
            dwe_log[cyc] = bus.dwe;
            da_log[cyc]  = int'(bus.daddr);
        end
        // Advance the model to the next cycle.
        if (rst) begin
            push_init();
        end else if (sched.size() > 0) begin
            r = sched.pop_front();
            if (r.last) m_hold = 1;
        end else if (m_hold) begin
            if (bus.out_ready) m_hold = 0;
        end else if (bus.clear) begin
            push_init();
        end else if (bus.in_valid) begin
            push_compute(m_wp);
            m_wp = (m_wp + 1) % N;
        end
    end

    task automatic send(input bit keep, output int t);
        bit ok;
        ok = 0;
        t  = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                t  = cyc;
                break;
            end
        end
        if (!ok) check("handshake_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int exp_rd[N] = '{0, 6, 5, 4, 3, 2, 1};
    int t, c, r0, nov;
    int ts[8];

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        cycles(3);

        // Reset release: zero fill over addresses 0..6, then idle.
        rst = 1'b0;
        r0 = cyc;
        cycles(9);
        for (int k = 0; k < N; k++) begin
            check("init_dwe", int'(dwe_log[r0 + k]), 1);
            check("init_daddr", da_log[r0 + k], k);
            check("init_op", int'(op_log[r0 + k]), int'(CLR));
        end
        check("init_idle_ready", int'(ir_log[r0 + N]), 1);

        // Single sample with immediate consumer.
        send(0, t);
        cycles(12);
        check("s1_wdaddr", da_log[t], 0);
        check("s1_dwe", int'(dwe_log[t]), 1);
        for (int j = 0; j < N; j++) check("s1_rdaddr", da_log[t + 1 + j], exp_rd[j]);
        check("s1_load_t2", int'(op_log[t + 2]), int'(LOAD));
        check("s1_nop_t1", int'(op_log[t + 1]), int'(NOP));
        check("s1_acc_t8", int'(op_log[t + 8]), int'(ACC));
        check("s1_ov_t8", int'(ov_log[t + 8]), 0);
        check("s1_ov_t9", int'(ov_log[t + 9]), 1);
        check("s1_ov_t10", int'(ov_log[t + 10]), 0);
        check("s1_ready_t10", int'(ir_log[t + 10]), 1);

        // clear together with in_valid while idle.
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        c = cyc;
        cycles(1);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        cycles(9);
        check("clr_ready", int'(ir_log[c]), 0);
        check("clr_dwe", int'(dwe_log[c + 1]), 1);
        check("clr_op", int'(op_log[c + 1]), int'(CLR));
        check("clr_daddr", da_log[c + 1], 0);

        // Eight back-to-back samples: write pointer wraps after 7.
        for (int i = 0; i < 8; i++) send(1, ts[i]);
        bus.in_valid = 1'b0;
        cycles(12);
        for (int i = 0; i < 8; i++) check("b2b_waddr", da_log[ts[i]], i % N);
        for (int j = 0; j < N; j++) check("b2b8_rdaddr", da_log[ts[7] + 1 + j], exp_rd[j]);

        // Result held for 5 cycles with in_valid pulses during DONE.
        send(0, t);
        bus.out_ready = 1'b0;
        cycles(8);
        for (int j = 0; j < 5; j++) begin
            bus.in_valid = j[0] ? 1'b0 : 1'b1;
            cycles(1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycles(4);
        for (int j = 0; j < 5; j++) begin
            check("hold_ov", int'(ov_log[t + 9 + j]), 1);
            check("hold_ready", int'(ir_log[t + 9 + j]), 0);
            check("hold_op", int'(op_log[t + 9 + j]), int'(NOP));
        end
        check("hold_release_ov", int'(ov_log[t + 15]), 0);
        check("hold_release_ready", int'(ir_log[t + 15]), 1);

        // Reset in the middle of a computation.
        send(0, t);
        cycles(3);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        r0 = cyc;
        bus.out_ready = 1'b0;
        cycles(4);
        bus.out_ready = 1'b1;
        cycles(16);
        nov = 0;
        for (int j = t; j < r0 + 18; j++) nov += int'(ov_log[j]);
        check("rst_no_ov", nov, 0);
        check("rst_init_dwe", int'(dwe_log[r0]), 1);
        check("rst_init_op", int'(op_log[r0]), int'(CLR));
        check("rst_init_daddr", da_log[r0], 0);
        check("rst_idle_ready", int'(ir_log[r0 + N]), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 The block SHALL have parameter NTAPS, default 7, giving the number of filter taps and the length of the sample delay line.
REQ-002 The block SHALL have parameter FADDRBITS, default $clog2(NTAPS), giving the width of the coefficient and delay-line addresses.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit, SHALL indicate that a new input sample is offered.
REQ-006 Port in_ready, output, 1 bit, SHALL indicate that a sample is accepted this cycle.
REQ-007 Port clear, input, 1 bit, SHALL request zeroing of the delay line.
REQ-008 Port dwe, output, 1 bit, SHALL be the delay-line write enable.
REQ-009 Port dzero, output, 1 bit, SHALL select zero as the delay-line write data instead of the input sample.
REQ-010 Port daddr, output, FADDRBITS bits, SHALL be the delay-line address for both write and read.
REQ-011 Port caddr, output, FADDRBITS bits, SHALL be the coefficient address.
REQ-012 Port mac_op, output, 2 bits, SHALL be the MAC command: NOP=00, LOAD=01, ACC=10, CLR=11.
REQ-013 Port out_valid, output, 1 bit, SHALL indicate that the MAC result is complete.
REQ-014 Port out_ready, input, 1 bit, SHALL indicate that the consumer takes the result.
REQ-015 Port busy, output, 1 bit, SHALL be 1 in every state except IDLE.

Function
REQ-016 The block SHALL implement five states: INIT (zero fill), IDLE, MAC (issue addresses), DRAIN (last MAC operation), DONE (result held).
REQ-017 The block SHALL keep a write pointer wp in the range 0..NTAPS-1 and a base register holding the address of the newest sample.
REQ-018 In INIT, for counter k=0..NTAPS-1, the block SHALL assert dwe=1, dzero=1, daddr=k and mac_op=CLR; after k=NTAPS-1 it SHALL load wp=0 and go to IDLE.
REQ-019 In IDLE, the block SHALL drive in_ready=1 and mac_op=NOP.
REQ-020 In IDLE, clear=1 SHALL take priority over in_valid: in_ready SHALL be 0 that cycle and the next state SHALL be INIT with k=0.
REQ-021 In IDLE, in_valid=1 with clear=0 SHALL be the handshake cycle T, in which the block drives dwe=1, dzero=0 and daddr=wp, loads base=wp, advances wp (NTAPS-1 wraps to 0) and enters MAC with k=0.
REQ-022 In MAC, the block SHALL drive caddr=k and daddr=(base-k) mod NTAPS, wrapping below 0 to NTAPS-1, with dwe=0, for k=0..NTAPS-1, then enter DRAIN.
REQ-023 mac_op SHALL be delayed one cycle from the addresses to match the synchronous read latency: LOAD in the cycle after k=0 is issued, ACC in the cycles after k=1..NTAPS-1 are issued.
REQ-024 The ACC for the last tap SHALL occur in the DRAIN state.
REQ-025 In DONE, the block SHALL drive out_valid=1 and mac_op=NOP; out_valid SHALL hold until out_ready=1, and the block SHALL return to IDLE on the cycle after that.
REQ-026 Latency SHALL be fixed: for handshake at cycle T, MAC runs T+1..T+NTAPS, LOAD occurs at T+2, DRAIN is at T+NTAPS+1, and out_valid first rises at T+NTAPS+2 (T+9 for NTAPS=7).
REQ-027 in_valid and clear outside IDLE SHALL be ignored and not queued; in_ready=0 and dwe=0 SHALL hold outside IDLE and INIT.
REQ-028 out_ready asserted outside DONE SHALL have no effect.
REQ-029 After NTAPS+1 accepted samples, wp SHALL wrap correctly and tap k SHALL always address the k-th newest sample.

Reset
REQ-030 While rst=1, the block SHALL drive in_ready=0, dwe=0, dzero=0, daddr=0, caddr=0, mac_op=NOP, out_valid=0 and busy=1.
REQ-031 On the edge with rst=1, the block SHALL load state=INIT, k=0, wp=0, base=0 and the mac_op pipeline register=NOP.
REQ-032 Reset asserted mid-operation SHALL abandon the computation with no out_valid and restart the INIT zero fill.

Verification
REQ-033 Release reset -> dwe=1, dzero=1, mac_op=CLR for 7 cycles with daddr=0..6, then IDLE with in_ready=1 and wp=0.
REQ-034 One sample at T with out_ready=1 -> daddr=0 written at T; caddr=0..6 and daddr=0,6,5,4,3,2,1 over T+1..T+7; LOAD at T+2; ACC at T+3..T+8; out_valid at T+9 only; in_ready=1 at T+10.
REQ-035 Eight back-to-back samples -> write addresses 0..6 then 0; for the 8th, daddr sequence is 0,6,5,4,3,2,1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and mac_op=NOP; in_valid pulses during DONE are ignored and in_ready stays 0.
REQ-037 clear and in_valid together in IDLE -> in_ready=0, INIT sequence runs, and the next sample is written at daddr=0.
REQ-038 rst at T+4 of a computation -> no out_valid; INIT restarts on the cycle after reset is released.
